prod_scheduler: RTL

//  Sequences the two 16-bit producers (fibonacci, timer) into the clk_1-side write port of the CDC buffer wrapper.

---
 rtl/prod_sched_pkg.sv | 19 +
 rtl/prod_scheduler_sat_counter.sv | 18 +
 rtl/prod_scheduler.sv | 87 ++++++++
 3 files changed

// File: rtl/prod_sched_pkg.sv
// prod_sched_pkg: shared state encodings, one-hot LED constants and defaults for prod_scheduler.
package prod_sched_pkg;
  localparam int DATA_W_DEF = 16;
  localparam logic [5:0] LED_IDLE      = 6'b000001;
  localparam logic [5:0] LED_COMM_F    = 6'b000010;
  localparam logic [5:0] LED_WAIT_F    = 6'b000100;
  localparam logic [5:0] LED_COMM_T    = 6'b001000;
  localparam logic [5:0] LED_WAIT_T    = 6'b010000;
  localparam logic [5:0] LED_BUF_EMPTY = 6'b100000;
  // State encoding is the LED pattern itself, so state_led needs no decode.
  typedef enum logic [5:0] {
    S_IDLE      = LED_IDLE,
    S_COMM_F    = LED_COMM_F,
    S_WAIT_F    = LED_WAIT_F,
    S_COMM_T    = LED_COMM_T,
    S_WAIT_T    = LED_WAIT_T,
    S_BUF_EMPTY = LED_BUF_EMPTY
  } state_t;
endpackage

// File: rtl/prod_scheduler_sat_counter.sv
// sat_counter: saturating up-counter with synchronous clear.
//  clk, rst (async, active-high) | inc: count up | clr: zero (wins over inc) | cnt: value, sticks at all-ones
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = clr ? '0 : (inc && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign cnt = cnt_q;
endmodule

// File: rtl/prod_scheduler.sv
// prod_scheduler: session FSM muxing fibonacci/timer samples into the clk_1 buffer write port.
//  in : clk, rst (async, active-high), start_f/start_t/stop pulses, buf_full, buf_empty, data_2_valid,
//       f_valid/f_out, t_valid/t_out
//  out: f_en, t_en, data_1_en/data_1 (combinational write port), state_led (one-hot), sample_cnt,
//       drop_err, drain_to
//  SCHED_DRAIN_TIMEOUT_EN: when defined, S_BUF_EMPTY gives up after DRAIN_TIMEOUT cycles and flags drain_to.
module prod_scheduler
  import prod_sched_pkg::*;
#(
  parameter int DATA_W        = DATA_W_DEF,
  parameter int CNT_W         = 16,
  parameter int DRAIN_TIMEOUT = 4096
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_f,
  input  logic              start_t,
  input  logic              stop,
  input  logic              buf_full,
  input  logic              buf_empty,
  input  logic              data_2_valid,
  input  logic              f_valid,
  input  logic [DATA_W-1:0] f_out,
  input  logic              t_valid,
  input  logic [DATA_W-1:0] t_out,
  output logic              f_en,
  output logic              t_en,
  output logic              data_1_en,
  output logic [DATA_W-1:0] data_1,
  output logic [5:0]        state_led,
  output logic [CNT_W-1:0]  sample_cnt,
  output logic              drop_err,
  output logic              drain_to
);
  state_t state_q, state_d;
  logic drop_q, drop_d, to_q, to_d;
  logic wr_f, wr_t, start, drained, timeout;
  assign wr_f    = state_q == S_COMM_F && f_valid && !buf_full;
  assign wr_t    = state_q == S_COMM_T && t_valid && !buf_full;
  assign start   = state_q == S_IDLE && (start_f || start_t);
  assign drained = buf_empty && !data_2_valid;
`ifdef SCHED_DRAIN_TIMEOUT_EN
  localparam int TW = $clog2(DRAIN_TIMEOUT + 1);
  logic [TW-1:0] tmr;
  // Held at zero outside S_BUF_EMPTY, so every drain starts counting from 0.
  sat_counter #(.W(TW)) u_drain (
    .clk(clk), .rst(rst), .inc(state_q == S_BUF_EMPTY), .clr(state_q != S_BUF_EMPTY), .cnt(tmr)
  );
  assign timeout = state_q == S_BUF_EMPTY && tmr == TW'(DRAIN_TIMEOUT - 1);
`else
  assign timeout = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:      state_d = start_f ? S_COMM_F : start_t ? S_COMM_T : S_IDLE;
      S_COMM_F:    state_d = stop ? S_BUF_EMPTY : buf_full ? S_WAIT_F : S_COMM_F;
      S_WAIT_F:    state_d = stop ? S_BUF_EMPTY : buf_full ? S_WAIT_F : S_COMM_F;
      S_COMM_T:    state_d = stop ? S_BUF_EMPTY : buf_full ? S_WAIT_T : S_COMM_T;
      S_WAIT_T:    state_d = stop ? S_BUF_EMPTY : buf_full ? S_WAIT_T : S_COMM_T;
      S_BUF_EMPTY: state_d = (drained || timeout) ? S_IDLE : S_BUF_EMPTY;
      default:     state_d = S_IDLE;
    endcase
    drop_d = start ? 1'b0 : drop_q | (f_valid && !wr_f) | (t_valid && !wr_t);
    to_d   = start ? 1'b0 : to_q | (timeout && !drained);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= S_IDLE;
      drop_q  <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      drop_q  <= drop_d;
      to_q    <= to_d;
    end
  sat_counter #(.W(CNT_W)) u_cnt (
    .clk(clk), .rst(rst), .inc(data_1_en), .clr(start), .cnt(sample_cnt)
  );
  assign f_en      = state_q == S_COMM_F;
  assign t_en      = state_q == S_COMM_T;
  assign data_1_en = wr_f || wr_t;
  assign data_1    = wr_f ? f_out : wr_t ? t_out : '0;
  assign state_led = state_q;
  assign drop_err  = drop_q;
  assign drain_to  = to_q;
endmodule
